// File: rtl/sdram_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_cmd_arbiter_if
// Bundles every engine-facing and pad-facing signal of the SDRAM command
// arbiter. The clock and reset are not part of this bundle.
//   slave  : arbiter side. It takes in the init, refresh and channel engine
//            signals and drives the pulses, the muxed pad bus and status.
//   master : engine/pad side. This is the mirror image of slave.
// Parameters:
//   NUM_CH : number of client engines
//   DW     : DQ width
//   AW     : address width
//   BAW    : bank address width
// ---------------------------------------------------------------------------
interface sdram_cmd_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int DW     = 24,
  parameter int AW     = 13,
  parameter int BAW    = 2
);
  // grant_id keeps at least one bit so that NUM_CH=1 stays legal
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  init_end;
  logic [3:0]            init_cmd;
  logic [AW-1:0]         init_addr;
  logic                  ref_req;
  logic                  ref_en;
  logic                  ref_end;
  logic [3:0]            ref_cmd;
  logic [AW-1:0]         ref_addr;
  logic [NUM_CH-1:0]     ch_req;
  logic [NUM_CH-1:0]     ch_we;
  logic [NUM_CH-1:0]     ch_en;
  logic [NUM_CH-1:0]     ch_end;
  logic [4*NUM_CH-1:0]   ch_cmd;
  logic [AW*NUM_CH-1:0]  ch_addr;
  logic [BAW*NUM_CH-1:0] ch_bank;
  logic [DW*NUM_CH-1:0]  ch_wdata;
  logic [3:0]            sdram_cmd;
  logic [AW-1:0]         sdram_addr;
  logic [BAW-1:0]        sdram_bank;
  logic [DW-1:0]         sdram_dq_out;
  logic                  sdram_dq_oe;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  init_end, init_cmd, init_addr,
    input  ref_req, ref_end, ref_cmd, ref_addr,
    input  ch_req, ch_we, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata,
    output ref_en, ch_en,
    output sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe,
    output grant_id, busy, timeout_err
  );

  modport master (
    output init_end, init_cmd, init_addr,
    output ref_req, ref_end, ref_cmd, ref_addr,
    output ch_req, ch_we, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata,
    input  ref_en, ch_en,
    input  sdram_cmd, sdram_addr, sdram_bank, sdram_dq_out, sdram_dq_oe,
    input  grant_id, busy, timeout_err
  );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_cmd_arbiter
// This block puts the init engine, the auto-refresh engine and NUM_CH burst
// engines onto one SDRAM command/address/bank/DQ bus.
//   - Refresh has fixed top priority.
//   - The client channels are served round-robin.
//   - A refresh never preempts a burst that is already running.
// Ports:
//   sclk  : controller clock
//   s_rst : asynchronous reset, active-high
//   bus   : sdram_cmd_arbiter_if.slave. It carries the engine handshakes
//           (req/en/end), the per-engine cmd/addr/bank/wdata, the muxed pad
//           outputs, grant_id, busy and timeout_err.
// Optional feature:
//   Define SDRAM_ARB_TIMEOUT_EN to build in a watchdog. The watchdog forces
//   the arbiter back to ARBIT when AREF or ACCESS lasts TIMEOUT_CYC cycles,
//   and it then sets the sticky timeout_err flag. When the macro is not
//   defined, timeout_err is tied to 0 and the arbiter waits for the end
//   pulses without any limit.
// ---------------------------------------------------------------------------
module sdram_cmd_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int DW          = 24,
  parameter int AW          = 13,
  parameter int BAW         = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                sclk,
  input  logic                s_rst,
  sdram_cmd_arbiter_if.slave  bus
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARBIT  = 2'd1,
    AREF   = 2'd2,
    ACCESS = 2'd3
  } state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_ptr;
  logic              gnt_we;
  logic              ref_pulse;
  logic [NUM_CH-1:0] ch_pulse;
  logic [GW-1:0]     win;
  logic              found;
  logic [NUM_CH-1:0] win_onehot;
  int                idx;
  int                gi;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] wd_cnt;
  logic          wd_expired;
  logic          err_flag;

  assign wd_expired = (wd_cnt == CW'(TIMEOUT_CYC - 1));
  assign bus.timeout_err = err_flag;
`else
  // The watchdog is not built, so TIMEOUT_CYC has no effect here
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
  assign bus.timeout_err = 1'b0;
`endif

  // Round-robin winner: take the first request found when scanning from rr_ptr+1 upward, wrapping modulo NUM_CH
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end else begin
        idx = idx;
      end
      if (!found && bus.ch_req[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end else begin
        found = found;
      end
    end
  end

  // One-hot form of the winning channel, loaded into ch_en
  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  // Integer copy of the registered grant, used to index the packed channel buses
  always_comb begin
    gi = int'(grant);
  end

  // Output mux: it is driven only by the registered state and grant, so its select lines never glitch
  always_comb begin
    bus.sdram_cmd  = 4'b0111;
    bus.sdram_addr = '0;
    bus.sdram_bank = '0;
    case (state)
      IDLE: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
      end
      ARBIT: begin
        bus.sdram_cmd  = 4'b0111;
      end
      AREF: begin
        bus.sdram_cmd  = bus.ref_cmd;
        bus.sdram_addr = bus.ref_addr;
      end
      ACCESS: begin
        bus.sdram_cmd  = bus.ch_cmd[gi*4 +: 4];
        bus.sdram_addr = bus.ch_addr[gi*AW +: AW];
        bus.sdram_bank = bus.ch_bank[gi*BAW +: BAW];
      end
      default: begin
        bus.sdram_cmd  = 4'b0111;
      end
    endcase
  end

  assign bus.sdram_dq_out = bus.ch_wdata[gi*DW +: DW];
  assign bus.sdram_dq_oe  = (state == ACCESS) && gnt_we;
  assign bus.busy         = (state == AREF) || (state == ACCESS);
  assign bus.ref_en       = ref_pulse;
  assign bus.ch_en        = ch_pulse;
  assign bus.grant_id     = grant;

  // Arbiter FSM. The start pulses and the grant are registered on the same edge as the state change
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state     <= IDLE;
      ref_pulse <= 1'b0;
      ch_pulse  <= '0;
      grant     <= '0;
      gnt_we    <= 1'b0;
      rr_ptr    <= GW'(NUM_CH - 1);
`ifdef SDRAM_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      err_flag  <= 1'b0;
`endif
    end else begin
      ref_pulse <= 1'b0;
      ch_pulse  <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      // The count restarts from 0 each time AREF or ACCESS is entered
      if ((state == AREF) || (state == ACCESS)) begin
        wd_cnt <= wd_cnt + CW'(1);
      end else begin
        wd_cnt <= '0;
      end
`endif
      case (state)
        IDLE: begin
          if (bus.init_end) begin
            state <= ARBIT;
          end else begin
            state <= IDLE;
          end
        end
        ARBIT: begin
          if (bus.ref_req) begin
            ref_pulse <= 1'b1;
            state     <= AREF;
          end else if (found) begin
            ch_pulse  <= win_onehot;
            grant     <= win;
            gnt_we    <= bus.ch_we[win];
            state     <= ACCESS;
          end else begin
            state     <= ARBIT;
          end
        end
        AREF: begin
          if (bus.ref_end) begin
            state <= ARBIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
          end else if (wd_expired) begin
            state    <= ARBIT;
            err_flag <= 1'b1;
`endif
          end else begin
            state <= AREF;
          end
        end
        ACCESS: begin
          // Only the end pulse of the granted channel counts. Moving rr_ptr to it gives the next channel priority
          if (bus.ch_end[grant]) begin
            state  <= ARBIT;
            rr_ptr <= grant;
`ifdef SDRAM_ARB_TIMEOUT_EN
          end else if (wd_expired) begin
            state    <= ARBIT;
            rr_ptr   <= grant;
            err_flag <= 1'b1;
`endif
          end else begin
            state <= ACCESS;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_cmd_arbiter
// Testbench for sdram_cmd_arbiter built with NUM_CH=4.
// Each channel has fixed cmd/addr/bank/wdata values taken from tables in the
// bench.
// The grant order the bench expects is pushed into a queue at the moment a
// request is raised. Each entry is popped when a ch_en pulse is seen.
// Inputs are driven on the falling edge of sclk, and outputs are sampled on
// the falling edge as well.
// ---------------------------------------------------------------------------
module tb_sdram_cmd_arbiter;
  localparam int NUM_CH = 4;
  localparam int DW     = 24;
  localparam int AW     = 13;
  localparam int BAW    = 2;

  logic sclk;
  logic s_rst;
  int   pass_cnt;
  int   total_cnt;
  int   exp_q[$];

  logic [3:0]     cmd_tbl   [NUM_CH];
  logic [AW-1:0]  addr_tbl  [NUM_CH];
  logic [BAW-1:0] bank_tbl  [NUM_CH];
  logic [DW-1:0]  wdata_tbl [NUM_CH];

  sdram_cmd_arbiter_if #(.NUM_CH(NUM_CH), .DW(DW), .AW(AW), .BAW(BAW)) bus ();

  sdram_cmd_arbiter #(
    .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .BAW(BAW), .TIMEOUT_CYC(16)
  ) dut (
    .sclk  (sclk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  // Wait a bounded number of cycles for a ch_en pulse
  task automatic wait_grant(output logic [3:0] en, output bit ok);
    en = 4'b0000;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge sclk);
      if (bus.ch_en != 4'b0000) begin
        en = bus.ch_en;
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    bus.init_cmd  = 4'b1010;
    bus.init_addr = 13'h0ABC;
    repeat (2) @(negedge sclk);
    total_cnt++; if (bus.ref_en !== 1'b0) $display("FAIL reset_ref_en got %b want 0", bus.ref_en); else pass_cnt++;
    total_cnt++; if (bus.ch_en !== 4'b0000) $display("FAIL reset_ch_en got %b want 0000", bus.ch_en); else pass_cnt++;
    total_cnt++; if (bus.grant_id !== 2'd0) $display("FAIL reset_grant got %0d want 0", bus.grant_id); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout_err got %b want 0", bus.timeout_err); else pass_cnt++;
    total_cnt++; if (bus.sdram_cmd !== 4'b1010) $display("FAIL reset_cmd got %b want 1010", bus.sdram_cmd); else pass_cnt++;
  endtask

  task automatic test_init();
    s_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.init_cmd  = 4'(c + 3);
      bus.init_addr = 13'(c * 7 + 1);
      #1;
      if (c == 2 || c == 7) begin
        total_cnt++; if (bus.sdram_cmd !== 4'(c + 3)) $display("FAIL init_cmd_follow got %b want %b", bus.sdram_cmd, 4'(c + 3)); else pass_cnt++;
        total_cnt++; if (bus.sdram_addr !== 13'(c * 7 + 1)) $display("FAIL init_addr_follow got %h want %h", bus.sdram_addr, 13'(c * 7 + 1)); else pass_cnt++;
      end
      @(negedge sclk);
    end
    bus.init_end = 1'b1;
    @(negedge sclk);
    total_cnt++; if (bus.sdram_cmd !== 4'b0111) $display("FAIL arbit_nop got %b want 0111", bus.sdram_cmd); else pass_cnt++;
    total_cnt++; if (bus.sdram_addr !== 13'h0000) $display("FAIL arbit_addr got %h want 0", bus.sdram_addr); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL arbit_busy got %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] en;
    logic [3:0] onehot;
    bit         ok;
    int         e;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    bus.ch_req = 4'b1111;
    bus.ch_we  = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      wait_grant(en, ok);
      e = exp_q.pop_front();
      onehot = 4'b0001 << e;
      total_cnt++; if (!ok || en !== onehot || bus.grant_id !== 2'(e)) $display("FAIL rr_grant%0d got en=%b id=%0d want en=%b id=%0d", n, en, bus.grant_id, onehot, e); else pass_cnt++;
      repeat (2) @(negedge sclk);
      total_cnt++; if (bus.busy !== 1'b1 || bus.sdram_cmd !== cmd_tbl[e] || bus.sdram_bank !== bank_tbl[e]) $display("FAIL rr_mux%0d got busy=%b cmd=%b bank=%0d want 1 %b %0d", n, bus.busy, bus.sdram_cmd, bus.sdram_bank, cmd_tbl[e], bank_tbl[e]); else pass_cnt++;
      repeat (5) @(negedge sclk);
      bus.ch_end = onehot;
      if (n == 4) bus.ch_req = 4'b0000;
      @(negedge sclk);
      bus.ch_end = 4'b0000;
    end
  endtask

  task automatic test_ref_priority();
    logic [3:0] en;
    bit         ok;
    int         e;
    bus.ref_req = 1'b1;
    bus.ch_req  = 4'b0010;
    exp_q.push_back(1);
    @(negedge sclk);
    total_cnt++; if (bus.ref_en !== 1'b1 || bus.ch_en !== 4'b0000) $display("FAIL ref_first got ref_en=%b ch_en=%b want 1 0000", bus.ref_en, bus.ch_en); else pass_cnt++;
    total_cnt++; if (bus.sdram_cmd !== 4'b0001 || bus.sdram_addr !== 13'h0400) $display("FAIL ref_mux got %b %h want 0001 0400", bus.sdram_cmd, bus.sdram_addr); else pass_cnt++;
    bus.ref_req = 1'b0;
    repeat (3) @(negedge sclk);
    total_cnt++; if (bus.ref_en !== 1'b0 || bus.busy !== 1'b1) $display("FAIL ref_hold got ref_en=%b busy=%b want 0 1", bus.ref_en, bus.busy); else pass_cnt++;
    bus.ref_end = 1'b1;
    @(negedge sclk);
    bus.ref_end = 1'b0;
    total_cnt++; if (bus.ch_en !== 4'b0000 || bus.sdram_cmd !== 4'b0111) $display("FAIL ref_rearb got ch_en=%b cmd=%b want 0000 0111", bus.ch_en, bus.sdram_cmd); else pass_cnt++;
    wait_grant(en, ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || en !== 4'b0010 || bus.grant_id !== 2'(e)) $display("FAIL ref_then_ch1 got en=%b id=%0d want 0010 %0d", en, bus.grant_id, e); else pass_cnt++;
    bus.ch_end = 4'b0010;
    bus.ch_req = 4'b0000;
    @(negedge sclk);
    bus.ch_end = 4'b0000;
  endtask

  task automatic test_write_read_dq();
    logic [3:0] en;
    bit         ok;
    int         e;
    bus.ch_req = 4'b0100;
    bus.ch_we  = 4'b0100;
    exp_q.push_back(2);
    wait_grant(en, ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || en !== 4'b0100) $display("FAIL wr_grant got %b want 0100", en); else pass_cnt++;
    total_cnt++; if (bus.sdram_dq_oe !== 1'b1 || bus.sdram_dq_out !== wdata_tbl[e]) $display("FAIL wr_dq got oe=%b dq=%h want 1 %h", bus.sdram_dq_oe, bus.sdram_dq_out, wdata_tbl[e]); else pass_cnt++;
    total_cnt++; if (bus.sdram_addr !== addr_tbl[e]) $display("FAIL wr_addr got %h want %h", bus.sdram_addr, addr_tbl[e]); else pass_cnt++;
    bus.ch_end = 4'b0100;
    bus.ch_req = 4'b0000;
    @(negedge sclk);
    bus.ch_end = 4'b0000;
    total_cnt++; if (bus.sdram_dq_oe !== 1'b0) $display("FAIL wr_oe_after got %b want 0", bus.sdram_dq_oe); else pass_cnt++;
    bus.ch_we  = 4'b0000;
    bus.ch_req = 4'b0100;
    exp_q.push_back(2);
    wait_grant(en, ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || en !== 4'b0100) $display("FAIL rd_grant got %b want 0100", en); else pass_cnt++;
    total_cnt++; if (bus.sdram_dq_oe !== 1'b0 || bus.sdram_dq_out !== wdata_tbl[e]) $display("FAIL rd_dq got oe=%b dq=%h want 0 %h", bus.sdram_dq_oe, bus.sdram_dq_out, wdata_tbl[e]); else pass_cnt++;
    bus.ch_end = 4'b0100;
    bus.ch_req = 4'b0000;
    @(negedge sclk);
    bus.ch_end = 4'b0000;
  endtask

  task automatic test_foreign_end_and_reset();
    logic [3:0] en;
    bit         ok;
    int         e;
    bus.ch_req = 4'b0010;
    exp_q.push_back(1);
    wait_grant(en, ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || en !== 4'b0010) $display("FAIL fe_grant got %b want 0010", en); else pass_cnt++;
    bus.ch_end = 4'b1000;
    @(negedge sclk);
    bus.ch_end = 4'b0000;
    @(negedge sclk);
    total_cnt++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'(e) || bus.sdram_cmd !== cmd_tbl[e]) $display("FAIL fe_stay got busy=%b id=%0d cmd=%b want 1 %0d %b", bus.busy, bus.grant_id, bus.sdram_cmd, e, cmd_tbl[e]); else pass_cnt++;
    s_rst = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0 || bus.ch_en !== 4'b0000 || bus.grant_id !== 2'd0) $display("FAIL mid_reset got busy=%b en=%b id=%0d want 0 0000 0", bus.busy, bus.ch_en, bus.grant_id); else pass_cnt++;
    total_cnt++; if (bus.sdram_cmd !== bus.init_cmd) $display("FAIL mid_reset_idle_mux got %b want %b", bus.sdram_cmd, bus.init_cmd); else pass_cnt++;
    @(negedge sclk);
    s_rst = 1'b0;
    bus.ch_req = 4'b0000;
    @(negedge sclk);
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); else pass_cnt++;
  endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] en;
    bit         ok;
    int         e;
    bus.ch_req = 4'b0001;
    exp_q.push_back(0);
    wait_grant(en, ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || en !== 4'b0001 || bus.grant_id !== 2'(e)) $display("FAIL to_grant got %b want 0001", en); else pass_cnt++;
    repeat (15) @(negedge sclk);
    total_cnt++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) $display("FAIL to_before got busy=%b err=%b want 1 0", bus.busy, bus.timeout_err); else pass_cnt++;
    @(negedge sclk);
    total_cnt++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) $display("FAIL to_fire got busy=%b err=%b want 0 1", bus.busy, bus.timeout_err); else pass_cnt++;
    bus.ch_req = 4'b0011;
    exp_q.push_back(1);
    wait_grant(en, ok);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || en !== 4'b0010 || bus.grant_id !== 2'(e)) $display("FAIL to_next got %b want 0010", en); else pass_cnt++;
    bus.ch_end = 4'b0010;
    bus.ch_req = 4'b0000;
    @(negedge sclk);
    bus.ch_end = 4'b0000;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmd_tbl[i]   = 4'(i + 8);
      addr_tbl[i]  = 13'(i * 16'h0111 + 16'h0020);
      bank_tbl[i]  = 2'(3 - i);
      wdata_tbl[i] = 24'(i * 24'h050505 + 24'h1A2B00);
    end
    s_rst         = 1'b1;
    bus.init_end  = 1'b0;
    bus.init_cmd  = 4'b0000;
    bus.init_addr = 13'h0000;
    bus.ref_req   = 1'b0;
    bus.ref_end   = 1'b0;
    bus.ref_cmd   = 4'b0001;
    bus.ref_addr  = 13'h0400;
    bus.ch_req    = 4'b0000;
    bus.ch_we     = 4'b0000;
    bus.ch_end    = 4'b0000;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_cmd[i*4 +: 4]       = cmd_tbl[i];
      bus.ch_addr[i*AW +: AW]    = addr_tbl[i];
      bus.ch_bank[i*BAW +: BAW]  = bank_tbl[i];
      bus.ch_wdata[i*DW +: DW]   = wdata_tbl[i];
    end
    test_reset();
    test_init();
    test_round_robin();
    test_ref_priority();
    test_write_read_dq();
    test_foreign_end_and_reset();
`ifdef SDRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
